bnn_layer_seq: RTL and testbench

- Sequences one fully-connected BNN layer over a bank of P parallel `neuron` lanes.
- Issues read addresses to the input-activation RAM and the weight RAM, then drives the lanes' shared `valid_in`/`last` strobes.
- Collects the P binary outputs per output group and presents them on a ready/valid stream.
- Sits between the layer buffers and the next layer's input buffer; one instance per layer.

---
 rtl/bnn_layer_pkg.sv | 19 +
 rtl/bnn_layer_seq_rd_align.sv | 29 ++
 rtl/bnn_layer_seq.sv | 161 ++++++++++++++++
 tb/tb_bnn_layer_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_layer_pkg.sv
// Shared types and default sizes for the BNN layer sequencer and its neuron bank.
package bnn_layer_pkg;

  localparam int BNN_PW           = 8;
  localparam int BNN_P            = 8;
  localparam int BNN_MAX_IN_BEATS = 128;
  localparam int BNN_MAX_GROUPS   = 64;
  localparam int BNN_IN_AW        = $clog2(BNN_MAX_IN_BEATS);
  localparam int BNN_WT_AW        = $clog2(BNN_MAX_IN_BEATS * BNN_MAX_GROUPS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_OUT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bnn_layer_seq_rd_align.sv
// Delays the read strobes by the RAM read latency so valid/last line up with RAM data at the lanes.
module bnn_rd_align
  import bnn_layer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rd_en,
  input  logic i_last_flag,
  output logic o_valid,
  output logic o_last
);

  logic r_valid_p0;
  logic r_last_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_p0 <= 1'b0;
      r_last_p0  <= 1'b0;
    end else begin
      r_valid_p0 <= i_rd_en;
      r_last_p0  <= i_rd_en && i_last_flag;
    end
  end

  assign o_valid = r_valid_p0;
  assign o_last  = r_last_p0;

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequences one fully-connected BNN layer: streams input/weight addresses to P lock-step
// neuron lanes, then hands each group's P binary outputs downstream on a ready/valid stream.
module bnn_layer_seq
  import bnn_layer_pkg::*;
#(
  parameter int P            = BNN_P,
  parameter int MAX_IN_BEATS = BNN_MAX_IN_BEATS,
  parameter int MAX_GROUPS   = BNN_MAX_GROUPS,
  parameter int IN_AW        = $clog2(MAX_IN_BEATS),
  parameter int WT_AW        = $clog2(MAX_IN_BEATS * MAX_GROUPS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(MAX_IN_BEATS+1)-1:0] cfg_in_beats,
  input  logic [$clog2(MAX_GROUPS+1)-1:0]   cfg_groups,
  output logic                              busy,
  output logic                              done,
  output logic [IN_AW-1:0]                  in_rd_addr,
  output logic [WT_AW-1:0]                  wt_rd_addr,
  output logic                              rd_en,
  output logic                              nrn_valid_in,
  output logic                              nrn_last,
  input  logic                              nrn_valid_out,
  input  logic [P-1:0]                      nrn_y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [P-1:0]                      out_data,
  output logic [$clog2(MAX_GROUPS)-1:0]     out_group
);

  localparam int CB_W = $clog2(MAX_IN_BEATS + 1);
  localparam int CG_W = $clog2(MAX_GROUPS + 1);
  localparam int GW   = $clog2(MAX_GROUPS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CB_W-1:0]  r_cfg_beats;
  logic [CG_W-1:0]  r_cfg_groups;
  logic [IN_AW-1:0] r_beat;
  logic [WT_AW-1:0] r_wptr;
  logic [GW-1:0]    r_group;
  logic [P-1:0]     r_out_data;
  logic             r_out_valid;
  logic             r_dbg_spurious;

  logic w_last_beat;
  logic w_last_group;
  logic w_start_acc;
  logic w_hs;
  logic w_rd_en;
  logic w_busy;
  logic w_done;

  assign w_last_beat  = (CB_W'(r_beat) == (r_cfg_beats - CB_W'(1)));
  assign w_last_group = (CG_W'(r_group) == (r_cfg_groups - CG_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A zero-sized layer drops straight into FIN, so its only visible activity is the done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_hs        = 1'b0;
    w_rd_en     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ((cfg_in_beats == '0) || (cfg_groups == '0)) ? ST_FIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        if (w_last_beat) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (nrn_valid_out) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_busy = 1'b1;
        if (out_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = w_last_group ? ST_FIN : ST_STREAM;
        end
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Weight pointer runs across groups because weights are stored group-major.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_beats    <= '0;
      r_cfg_groups   <= '0;
      r_beat         <= '0;
      r_wptr         <= '0;
      r_group        <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_dbg_spurious <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_cfg_beats  <= cfg_in_beats;
        r_cfg_groups <= cfg_groups;
        r_beat       <= '0;
        r_wptr       <= '0;
        r_group      <= '0;
      end
      if (w_rd_en) begin
        r_wptr <= r_wptr + WT_AW'(1);
        r_beat <= w_last_beat ? '0 : r_beat + IN_AW'(1);
      end
      if ((r_state == ST_WAIT) && nrn_valid_out) begin
        r_out_data  <= nrn_y;
        r_out_valid <= 1'b1;
      end
      if (w_hs) begin
        r_out_valid <= 1'b0;
        if (!w_last_group) r_group <= r_group + GW'(1);
      end
      if (nrn_valid_out && (r_state != ST_WAIT)) r_dbg_spurious <= 1'b1;
    end
  end

  bnn_rd_align u_rd_align (
    .clk         (clk),
    .rst         (rst),
    .i_rd_en     (w_rd_en),
    .i_last_flag (w_last_beat),
    .o_valid     (nrn_valid_in),
    .o_last      (nrn_last)
  );

  assign busy       = w_busy;
  assign done       = w_done;
  assign rd_en      = w_rd_en;
  assign in_rd_addr = r_beat;
  assign wt_rd_addr = r_wptr;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_group  = r_group;

  a_last_has_valid: assert property (@(posedge clk) disable iff (rst) nrn_last |-> nrn_valid_in);
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_group)));
  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_no_spurious_vo: assert property (@(posedge clk) disable iff (rst) !r_dbg_spurious);

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq with a lock-step neuron-bank model and a negedge event recorder.
module tb_bnn_layer_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_in_beats = '0;
  logic [6:0] cfg_groups = '0;
  logic       busy, done, rd_en, nrn_valid_in, nrn_last, out_valid;
  logic [6:0] in_rd_addr;
  logic [12:0] wt_rd_addr;
  logic       nrn_valid_out;
  logic [7:0] nrn_y;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [5:0] out_group;
  logic       clr = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bnn_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_beats(cfg_in_beats), .cfg_groups(cfg_groups),
    .busy(busy), .done(done), .in_rd_addr(in_rd_addr), .wt_rd_addr(wt_rd_addr), .rd_en(rd_en),
    .nrn_valid_in(nrn_valid_in), .nrn_last(nrn_last), .nrn_valid_out(nrn_valid_out),
    .nrn_y(nrn_y), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_group(out_group)
  );

  // Neuron bank: result one cycle after last; group k yields {k[3:0], ~k[3:0]}, then y toggles.
  int lcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nrn_valid_out <= 1'b0;
      nrn_y         <= '0;
      lcnt          <= 0;
    end else begin
      nrn_valid_out <= nrn_last;
      if (clr) lcnt <= 0;
      if (nrn_last) begin
        nrn_y <= {lcnt[3:0], ~lcnt[3:0]};
        lcnt  <= lcnt + 1;
      end else begin
        nrn_y <= ~nrn_y;
      end
    end
  end

  int cyc = 0;
  int in_a[64], wt_a[64], rd_cyc[64], grp_a[64], dat_a[64], hs_cyc[64];
  int n_rd, n_hs, nvi, nl, nov, ndone, done_cyc, nvi_cyc0, nl_cyc, ov_cyc0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      n_rd <= 0; n_hs <= 0; nvi <= 0; nl <= 0; nov <= 0; ndone <= 0;
      done_cyc <= -1; nvi_cyc0 <= -1; nl_cyc <= -1; ov_cyc0 <= -1;
    end else begin
      if (rd_en && n_rd < 64) begin
        in_a[n_rd] <= int'(in_rd_addr); wt_a[n_rd] <= int'(wt_rd_addr);
        rd_cyc[n_rd] <= cyc; n_rd <= n_rd + 1;
      end
      if (nrn_valid_in) begin
        if (nvi == 0) nvi_cyc0 <= cyc;
        nvi <= nvi + 1;
      end
      if (nrn_last) begin nl <= nl + 1; nl_cyc <= cyc; end
      if (out_valid) begin
        if (nov == 0) ov_cyc0 <= cyc;
        nov <= nov + 1;
      end
      if (out_valid && out_ready && n_hs < 64) begin
        grp_a[n_hs] <= int'(out_group); dat_a[n_hs] <= int'(out_data);
        hs_cyc[n_hs] <= cyc; n_hs <= n_hs + 1;
      end
      if (done) begin ndone <= ndone + 1; done_cyc <= cyc; end
    end
  end

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic start_layer(input int b, input int g);
    pulse_clr();
    cfg_in_beats = 8'(b);
    cfg_groups   = 7'(g);
    start        = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (ndone > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, done, rd_en, nrn_valid_in, nrn_last, out_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000000", {busy, done, rd_en, nrn_valid_in, nrn_last, out_valid}); end
    total++; if ({in_rd_addr, wt_rd_addr} !== 20'd0) begin
      bad++; $display("FAIL reset_addr got in=%0d wt=%0d exp 0/0", in_rd_addr, wt_rd_addr); end
    total++; if ({out_data, out_group} !== 14'd0) begin
      bad++; $display("FAIL reset_out got data=%h grp=%0d exp 0/0", out_data, out_group); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    out_ready = 1'b1;
    start_layer(4, 1);
    wait_done(40, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%0b exp=1", ok); end
    total++; if (n_rd !== 4) begin bad++; $display("FAIL single_nrd got=%0d exp=4", n_rd); end
    for (int i = 0; i < 4; i++) begin
      total++; if (in_a[i] !== i || wt_a[i] !== i) begin
        bad++; $display("FAIL single_addr[%0d] got in=%0d wt=%0d exp %0d", i, in_a[i], wt_a[i], i); end
    end
    total++; if (nvi !== 4 || nl !== 1) begin bad++; $display("FAIL single_strobes got vi=%0d last=%0d exp 4/1", nvi, nl); end
    total++; if (nvi_cyc0 - rd_cyc[0] !== 1) begin bad++; $display("FAIL single_vi_lat got=%0d exp=1", nvi_cyc0 - rd_cyc[0]); end
    total++; if (nl_cyc - nvi_cyc0 !== 3) begin bad++; $display("FAIL single_last_pos got=%0d exp=3", nl_cyc - nvi_cyc0); end
    total++; if (ov_cyc0 - rd_cyc[0] !== 6) begin bad++; $display("FAIL single_ov_lat got=%0d exp=6", ov_cyc0 - rd_cyc[0]); end
    total++; if (n_hs !== 1 || grp_a[0] !== 0 || dat_a[0] !== 32'h0F) begin
      bad++; $display("FAIL single_out got hs=%0d grp=%0d data=%h exp 1/0/0f", n_hs, grp_a[0], dat_a[0]); end
    total++; if (nov !== 1) begin bad++; $display("FAIL single_ov_len got=%0d exp=1", nov); end
    total++; if (ndone !== 1 || done_cyc - hs_cyc[0] !== 1) begin
      bad++; $display("FAIL single_done got n=%0d dly=%0d exp 1/1", ndone, done_cyc - hs_cyc[0]); end
  endtask

  task automatic test_multi_group();
    bit ok;
    int exp_dat[3] = '{32'h0F, 32'h1E, 32'h2D};
    out_ready = 1'b1;
    start_layer(3, 3);
    wait_done(80, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL multi_timeout got=%0b exp=1", ok); end
    total++; if (n_rd !== 9) begin bad++; $display("FAIL multi_nrd got=%0d exp=9", n_rd); end
    for (int i = 0; i < 9; i++) begin
      total++; if (in_a[i] !== i % 3 || wt_a[i] !== i) begin
        bad++; $display("FAIL multi_addr[%0d] got in=%0d wt=%0d exp %0d/%0d", i, in_a[i], wt_a[i], i % 3, i); end
    end
    total++; if (n_hs !== 3) begin bad++; $display("FAIL multi_nhs got=%0d exp=3", n_hs); end
    for (int g = 0; g < 3; g++) begin
      total++; if (grp_a[g] !== g || dat_a[g] !== exp_dat[g]) begin
        bad++; $display("FAIL multi_out[%0d] got grp=%0d data=%h exp %0d/%h", g, grp_a[g], dat_a[g], g, exp_dat[g]); end
    end
    total++; if (hs_cyc[1] - hs_cyc[0] !== 6) begin bad++; $display("FAIL multi_thru got=%0d exp=6", hs_cyc[1] - hs_cyc[0]); end
    total++; if (nvi !== 9 || nl !== 3) begin bad++; $display("FAIL multi_strobes got vi=%0d last=%0d exp 9/3", nvi, nl); end
    total++; if (ndone !== 1 || done_cyc - hs_cyc[2] !== 1) begin
      bad++; $display("FAIL multi_done got n=%0d dly=%0d exp 1/1", ndone, done_cyc - hs_cyc[2]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stall_bad;
    out_ready = 1'b0;
    start_layer(2, 2);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin ok = 1'b1; break; end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_ov_timeout got=%0b exp=1", ok); end
    stall_bad = 0;
    repeat (10) begin
      if (out_valid !== 1'b1 || out_data !== 8'h0F || out_group !== 6'd0 || rd_en !== 1'b0) stall_bad++;
      @(posedge clk); #1;
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", stall_bad); end
    total++; if (n_rd !== 2) begin bad++; $display("FAIL bp_no_rd got=%0d exp=2", n_rd); end
    out_ready = 1'b1;
    wait_done(40, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%0b exp=1", ok); end
    total++; if (n_hs !== 2 || grp_a[0] !== 0 || grp_a[1] !== 1) begin
      bad++; $display("FAIL bp_groups got n=%0d g0=%0d g1=%0d exp 2/0/1", n_hs, grp_a[0], grp_a[1]); end
    total++; if (dat_a[0] !== 32'h0F || dat_a[1] !== 32'h1E) begin
      bad++; $display("FAIL bp_data got %h %h exp 0f 1e", dat_a[0], dat_a[1]); end
    total++; if (n_rd !== 4 || wt_a[2] !== 2 || wt_a[3] !== 3) begin
      bad++; $display("FAIL bp_g1_addr got n=%0d wt=%0d,%0d exp 4/2,3", n_rd, wt_a[2], wt_a[3]); end
    total++; if (rd_cyc[2] - hs_cyc[0] !== 1) begin
      bad++; $display("FAIL bp_g1_start got=%0d exp=1", rd_cyc[2] - hs_cyc[0]); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", ndone); end
  endtask

  task automatic test_zero_cfg();
    bit ok;
    int cfgs[2][2] = '{'{0, 3}, '{4, 0}};
    for (int k = 0; k < 2; k++) begin
      start_layer(cfgs[k][0], cfgs[k][1]);
      wait_done(10, ok);
      total++; if (ok !== 1'b1 || ndone !== 1) begin
        bad++; $display("FAIL zero%0d_done got ok=%0b n=%0d exp 1/1", k, ok, ndone); end
      total++; if (n_rd !== 0 || nvi !== 0 || nov !== 0) begin
        bad++; $display("FAIL zero%0d_quiet got rd=%0d vi=%0d ov=%0d exp 0/0/0", k, n_rd, nvi, nov); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    out_ready = 1'b1;
    start_layer(3, 2);
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL swb_busy got=%0b exp=1", busy); end
    cfg_in_beats = 8'd5;
    cfg_groups   = 7'd1;
    start        = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL swb_timeout got=%0b exp=1", ok); end
    total++; if (n_rd !== 6 || in_a[5] !== 2 || wt_a[5] !== 5) begin
      bad++; $display("FAIL swb_reads got n=%0d in5=%0d wt5=%0d exp 6/2/5", n_rd, in_a[5], wt_a[5]); end
    total++; if (n_hs !== 2 || ndone !== 1) begin
      bad++; $display("FAIL swb_hs got hs=%0d done=%0d exp 2/1", n_hs, ndone); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    start_layer(4, 2);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (n_hs == 1) begin ok = 1'b1; break; end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_hs_timeout got=%0b exp=1", ok); end
    @(posedge clk); #1;
    total++; if (rd_en !== 1'b1 || in_rd_addr !== 7'd1 || wt_rd_addr !== 13'd5) begin
      bad++; $display("FAIL rmid_pre got rd=%0b in=%0d wt=%0d exp 1/1/5", rd_en, in_rd_addr, wt_rd_addr); end
    #2 rst = 1'b1;
    #1;
    total++; if ({busy, done, rd_en, nrn_valid_in, nrn_last, out_valid, in_rd_addr, wt_rd_addr, out_data, out_group} !== '0) begin
      bad++; $display("FAIL rmid_zero got busy=%0b rd=%0b vi=%0b ov=%0b in=%0d wt=%0d grp=%0d exp all 0",
                      busy, rd_en, nrn_valid_in, out_valid, in_rd_addr, wt_rd_addr, out_group); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (ndone !== 0 || n_hs !== 1) begin
      bad++; $display("FAIL rmid_nodone got done=%0d hs=%0d exp 0/1", ndone, n_hs); end
    start_layer(2, 1);
    wait_done(30, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_rerun_timeout got=%0b exp=1", ok); end
    total++; if (n_rd !== 2 || in_a[0] !== 0 || in_a[1] !== 1 || wt_a[0] !== 0 || wt_a[1] !== 1) begin
      bad++; $display("FAIL rmid_rerun_addr got n=%0d in=%0d,%0d wt=%0d,%0d exp 2/0,1/0,1",
                      n_rd, in_a[0], in_a[1], wt_a[0], wt_a[1]); end
    total++; if (n_hs !== 1 || grp_a[0] !== 0 || dat_a[0] !== 32'h0F || ndone !== 1) begin
      bad++; $display("FAIL rmid_rerun_out got hs=%0d grp=%0d data=%h done=%0d exp 1/0/0f/1",
                      n_hs, grp_a[0], dat_a[0], ndone); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_group();
    test_backpressure();
    test_zero_cfg();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
